// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_unit
//  Description : Sequential instruction-fetch initiator for a word-addressed
//                synchronous-address / combinational-data instruction memory.
//                Tags each returned instruction with its PC, holds the fetch
//                address during decode stalls and restarts on redirects.
//  Revision    : 1.0  initial release
// ============================================================================
module ifetch_unit #(
    parameter logic [29:0] RESET_PC = 30'h00000000,
    parameter int          COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    output logic [29:0]        imem_addr,
    input  logic [31:0]        imem_inst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [29:0]        redirect_addr,
    output logic               inst_valid,
    output logic [31:0]        inst,
    output logic [29:0]        inst_pc,
    output logic [31:0]        inst_pc_byte,
    output logic [COUNT_W-1:0] fetch_count
);

    localparam logic [29:0]        c_PC_ONE    = 30'd1;
    localparam logic [COUNT_W-1:0] c_COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    // Address whose data the memory is currently returning, and whether it is live
    logic [29:0]        r_req_pc;
    logic               r_req_valid;
    logic [COUNT_W-1:0] r_fetch_count;

    logic [29:0]        w_fetch_addr;
    logic               w_inst_valid;
    logic               w_accept;

    // Next fetch address: redirect beats everything; after reset the start
    // address is re-presented so a memory with a different reset address
    // resynchronises; a stall re-presents the held address so memory data
    // stays put; otherwise advance one word (wrapping at 2^30).
    always_comb begin
        w_fetch_addr = r_req_pc + c_PC_ONE;
        if (rst) begin
            w_fetch_addr = RESET_PC;
        end else if (redirect_valid) begin
            w_fetch_addr = redirect_addr;
        end else if (!r_req_valid) begin
            w_fetch_addr = RESET_PC;
        end else if (stall) begin
            w_fetch_addr = r_req_pc;
        end
    end

    // A redirect squashes the wrong-path instruction in the same cycle
    assign w_inst_valid = r_req_valid & ~redirect_valid;
    assign w_accept     = w_inst_valid & ~stall;

    // Track the address the memory latched this edge and count accepted fetches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_pc      <= RESET_PC;
            r_req_valid   <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_req_pc    <= w_fetch_addr;
            r_req_valid <= 1'b1;
            if (w_accept) begin
                r_fetch_count <= r_fetch_count + c_COUNT_ONE;
            end
        end
    end

    assign imem_addr    = w_fetch_addr;
    assign inst         = imem_inst;
    assign inst_pc      = r_req_pc;
    assign inst_pc_byte = {r_req_pc, 2'b00};
    assign inst_valid   = w_inst_valid;
    assign fetch_count  = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifetch_unit
//  Description : Self-checking bench for ifetch_unit with a ROM model whose
//                address register resets to 0. Expected accepted
//                instructions are queued by the stimulus and popped by a
//                monitor on each accept.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ifetch_unit;

    logic        clk;
    logic        rst;
    logic [29:0] imem_addr;
    logic [31:0] imem_inst;
    logic        stall;
    logic        redirect_valid;
    logic [29:0] redirect_addr;
    logic        inst_valid;
    logic [31:0] inst;
    logic [29:0] inst_pc;
    logic [31:0] inst_pc_byte;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [29:0] pc;
    } exp_t;

    exp_t exp_q[$];

    ifetch_unit #(
        .RESET_PC (30'h00000000),
        .COUNT_W  (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_pc_byte   (inst_pc_byte),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: a few fixed words, everything else a recognisable pattern
    function automatic logic [31:0] rom_word(input logic [29:0] a);
        case (a)
            30'h00000000: rom_word = 32'h3c1d1000;
            30'h00000001: rom_word = 32'h37bd0100;
            30'h00000002: rom_word = 32'h3c028000;
            30'h00000004: rom_word = 32'h3c0a10d0;
            30'h0000000A: rom_word = 32'hac4c001c;
            default:      rom_word = 32'hE0000000 | {2'b00, a};
        endcase
    endfunction

    // Memory model: address latched at posedge, reset to 0, data combinational
    logic [29:0] mem_addr_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_addr_q <= 30'd0;
        else     mem_addr_q <= imem_addr;
    end
    assign imem_inst = rom_word(mem_addr_q);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted instruction must match the head of the queue
    always @(negedge clk) begin
        if (!rst && inst_valid && !stall) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_accept: got pc %0h inst %0h expected none", inst_pc, inst);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("acc_inst",    {32'd0, inst},         {32'd0, e.inst});
                chk("acc_pc",      {34'd0, inst_pc},      {34'd0, e.pc});
                chk("acc_pc_byte", {32'd0, inst_pc_byte}, {32'd0, e.pc, 2'b00});
            end
        end
    end

    // Advance to the next cycle, drive inputs, optionally queue an expected accept
    task automatic step(input logic s, input logic rv, input logic [29:0] ra,
                        input logic acc, input logic [29:0] pc);
        @(posedge clk);
        #1;
        stall          = s;
        redirect_valid = rv;
        redirect_addr  = ra;
        if (acc) exp_q.push_back({rom_word(pc), pc});
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = 30'd0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_addr",  {34'd0, imem_addr},  64'd0);
        chk("rst_pc",    {34'd0, inst_pc},    64'd0);
        chk("rst_count", {32'd0, fetch_count}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Straight-line stream
        step(0, 0, 0, 1, 30'd0);
        chk("c1_valid", {63'd0, inst_valid}, 64'd1);
        step(0, 0, 0, 1, 30'd1);
        step(0, 0, 0, 1, 30'd2);
        // Redirect back to 1 to set up the stall; check count first
        step(0, 1, 30'd1, 0, 0);
        chk("count_3",       {32'd0, fetch_count}, 64'd3);
        chk("redir1_valid",  {63'd0, inst_valid},  64'd0);
        chk("redir1_addr",   {34'd0, imem_addr},   64'd1);

        // Three-cycle stall holding pc 1
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0);
            chk("stall_addr",  {34'd0, imem_addr},   64'd1);
            chk("stall_pc",    {34'd0, inst_pc},     64'd1);
            chk("stall_inst",  {32'd0, inst},        64'h37bd0100);
            chk("stall_count", {32'd0, fetch_count}, 64'd3);
        end
        step(0, 0, 0, 1, 30'd1);

        // Redirect while pc 2
        step(0, 1, 30'h0A, 0, 0);
        chk("redir_pc",    {34'd0, inst_pc},    64'd2);
        chk("redir_valid", {63'd0, inst_valid}, 64'd0);
        chk("redir_addr",  {34'd0, imem_addr},  64'h0A);
        step(0, 0, 0, 1, 30'h0A);
        chk("count_sq",    {32'd0, fetch_count}, 64'd4);

        // Redirect and stall together: redirect wins
        step(1, 1, 30'd4, 0, 0);
        chk("rs_addr",  {34'd0, imem_addr},  64'd4);
        chk("rs_valid", {63'd0, inst_valid}, 64'd0);
        step(0, 0, 0, 1, 30'd4);
        chk("count_rs", {32'd0, fetch_count}, 64'd5);

        // Address wrap at top of the word space
        step(0, 1, 30'h3FFFFFFF, 0, 0);
        step(0, 0, 0, 1, 30'h3FFFFFFF);
        chk("wrap_addr", {34'd0, imem_addr}, 64'd0);
        step(0, 0, 0, 1, 30'd0);
        step(0, 0, 0, 1, 30'd1);
        step(0, 0, 0, 1, 30'd2);

        // Asynchronous reset in the middle of a stall at pc 3
        step(1, 0, 0, 0, 0);
        chk("pre_rst_pc",    {34'd0, inst_pc},     64'd3);
        chk("pre_rst_count", {32'd0, fetch_count}, 64'd10);
        rst = 1'b1;
        #1;
        chk("arst_valid", {63'd0, inst_valid},  64'd0);
        chk("arst_addr",  {34'd0, imem_addr},   64'd0);
        chk("arst_count", {32'd0, fetch_count}, 64'd0);
        chk("arst_pc",    {34'd0, inst_pc},     64'd0);
        @(negedge clk);
        stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 1, 30'd0);
        step(1, 0, 0, 0, 0);
        chk("post_count", {32'd0, fetch_count}, 64'd1);
        repeat (2) @(posedge clk);
        chk("queue_empty", {32'd0, 32'(exp_q.size())}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
